victim_alloc_ctrl: RTL and testbench
====================================

# victim_alloc_ctrl

Sequences allocation of a way in one L2 cache set after a processor miss. If the set has an INVALID way, it grants that way at once. Otherwise it picks a victim way, writes the victim back first if it is MODIFIED, invalidates it, then grants it. It sits between the L2 miss path (requester) and the writeback/tag-update logic, and it is the only block that hands out allocation ways.

## Interface
Parameters:
- ASSOC, `ASSOC_LV2, ways per set
- ASSOC_WID, `ASSOC_WID_LV2, way index width
- MESI_WID, `MESI_WID_LV2, MESI state width per way
- INVALID, 0, MESI encoding of Invalid
- MODIFIED, 3, MESI encoding of Modified

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- alloc_req  in  1  miss needs a way; held high until alloc_gnt
- blk_hit_proc  in  1  access hit; while high, alloc_req is ignored in IDLE
- cache_proc_mesi  in  ASSOC*MESI_WID  set MESI states; way i at bits [(i+1)*MESI_WID-1 : i*MESI_WID]
- lru_blk_num  in  ASSOC_WID  LRU way from the replacement logic
- wb_ack  in  1  writeback of wb_blk_num accepted
- busy  out  1  high in every state except IDLE
- wb_req  out  1  writeback request; level, held until wb_ack
- wb_blk_num  out  ASSOC_WID  way to write back
- inv_req  out  1  one-cycle pulse: set the way on inv_blk_num to INVALID
- inv_blk_num  out  ASSOC_WID  way to invalidate
- alloc_gnt  out  1  one-cycle grant pulse
- alloc_blk_num  out  ASSOC_WID  granted way; valid while alloc_gnt=1

## Operation
- States: IDLE, WB, INV, GRANT. All outputs are registered.
- IDLE with alloc_req=1 and blk_hit_proc=0 starts a decision, made combinationally from the current cache_proc_mesi:
  - free way: the highest-index way whose MESI equals INVALID; latch it and go to GRANT.
  - no free way: the victim is lru_blk_num (see Configuration).
  - victim MESI == MODIFIED: latch the victim and go to WB.
  - victim not MODIFIED: latch the victim and go to INV.
- IDLE with alloc_req=0, or with blk_hit_proc=1: stay in IDLE.
- WB: wb_req=1 and wb_blk_num=victim. On wb_ack=1, go to INV on the next cycle. wb_ack seen in any other state is ignored.
- INV: inv_req=1 and inv_blk_num=victim for exactly one cycle, then go to GRANT.
- GRANT: alloc_gnt=1 and alloc_blk_num=latched way for exactly one cycle, then go to IDLE.
- The victim is latched at decision time. Later changes to cache_proc_mesi or lru_blk_num do not affect the sequence in progress.
- If alloc_req drops after the decision, the sequence still runs to completion and alloc_gnt still pulses. The requester discards it.
- Way-index arithmetic is modulo ASSOC. ASSOC must be a power of two.

## Timing
- Reset (rst_n=0 at a clock edge):
  - state=IDLE
  - busy, wb_req, inv_req and alloc_gnt = 0
  - wb_blk_num, inv_blk_num and alloc_blk_num = 0
  - round-robin pointer = 0 (when configured in)
- Reset mid-sequence aborts the sequence on that edge. A pending wb_req drops, and no grant is issued.
- Latency, with alloc_req first seen at edge 0:
  - free way: alloc_gnt high in cycle 1.
  - clean victim: inv_req high in cycle 1, alloc_gnt high in cycle 2.
  - dirty victim: wb_req rises in cycle 1. If wb_ack is sampled at edge k, inv_req is high in cycle k+1 and alloc_gnt in cycle k+2.
- Minimum wb_req duration is 1 cycle (wb_ack returned in cycle 1).
- Back-to-back: a new alloc_req is accepted in the first IDLE cycle after GRANT.

## Configuration
- ALLOC_RR_VICTIM_EN defined:
  - the victim is an internal ASSOC_WID round-robin pointer; lru_blk_num is ignored.
  - the pointer increments, wrapping ASSOC-1 to 0, on each cycle where inv_req=1.
- ALLOC_RR_VICTIM_EN undefined:
  - the victim is lru_blk_num; no pointer register exists.

## Test plan
Setup for all scenarios: ASSOC=4, MESI_WID=2.
- Free way: mesi={3,0,1,0} (way3..way0), req=1 → alloc_gnt in cycle 1, alloc_blk_num=2; wb_req and inv_req never assert.
- Clean victim: mesi={1,2,1,2}, lru=1 → inv_req with inv_blk_num=1 in cycle 1; alloc_gnt with alloc_blk_num=1 in cycle 2.
- Dirty victim: mesi={3,3,3,3}, lru=2, wb_ack at edge 4 → wb_req with wb_blk_num=2 in cycles 1–4; inv_req in cycle 5; alloc_gnt in cycle 6.
- Hit and drop:
  - blk_hit_proc=1 with req=1 → stays IDLE, busy=0.
  - req dropped in WB → wb_ack still leads to INV and GRANT.
- Reset: rst_n=0 in cycle 2 of WB → all outputs 0 next cycle, state IDLE; a new req proceeds normally.
- With ALLOC_RR_VICTIM_EN and all ways valid: five allocations → victims 0,1,2,3,0, regardless of lru.

Source files
------------

// File: rtl/victim_alloc_ctrl_if.sv
// victim_alloc_ctrl_if
// Bundles the handshake between the L2 miss path, the allocation controller
// and the writeback/tag-update logic.
// - The slave modport is the controller's view.
// - The master modport is the view of the surrounding logic, which drives
//   requests and set state.
// The ASSOC_LV2 / ASSOC_WID_LV2 / MESI_WID_LV2 macros fall back to a 4-way
// set with 2-bit MESI states when the build does not define them.

`ifndef ASSOC_LV2
`define ASSOC_LV2 4
`endif
`ifndef ASSOC_WID_LV2
`define ASSOC_WID_LV2 2
`endif
`ifndef MESI_WID_LV2
`define MESI_WID_LV2 2
`endif

interface victim_alloc_ctrl_if #(
   parameter int ASSOC     = `ASSOC_LV2,
   parameter int ASSOC_WID = `ASSOC_WID_LV2,
   parameter int MESI_WID  = `MESI_WID_LV2
);

   // Requester side
   logic                      alloc_req;
   logic                      blk_hit_proc;
   logic [ASSOC*MESI_WID-1:0] cache_proc_mesi;
   logic [ASSOC_WID-1:0]      lru_blk_num;
   logic                      alloc_gnt;
   logic [ASSOC_WID-1:0]      alloc_blk_num;
   logic                      busy;

   // Writeback / tag-update side
   logic                      wb_req;
   logic [ASSOC_WID-1:0]      wb_blk_num;
   logic                      wb_ack;
   logic                      inv_req;
   logic [ASSOC_WID-1:0]      inv_blk_num;

   modport master (
      output alloc_req,
      output blk_hit_proc,
      output cache_proc_mesi,
      output lru_blk_num,
      output wb_ack,
      input  busy,
      input  wb_req,
      input  wb_blk_num,
      input  inv_req,
      input  inv_blk_num,
      input  alloc_gnt,
      input  alloc_blk_num
   );

   modport slave (
      input  alloc_req,
      input  blk_hit_proc,
      input  cache_proc_mesi,
      input  lru_blk_num,
      input  wb_ack,
      output busy,
      output wb_req,
      output wb_blk_num,
      output inv_req,
      output inv_blk_num,
      output alloc_gnt,
      output alloc_blk_num
   );

endinterface

// File: rtl/victim_alloc_ctrl.sv
// victim_alloc_ctrl
// Hands out an allocation way in one L2 set after a processor miss.
// - An INVALID way is granted directly.
// - Otherwise a victim is chosen. A MODIFIED victim is written back first,
//   then the victim is invalidated and granted.
// - All outputs come straight from flops.
// Optional feature: define ALLOC_RR_VICTIM_EN to take victims from an internal
// round-robin pointer instead of lru_blk_num.
// ASSOC must be a power of two, so the way-index arithmetic wraps naturally.

`ifndef ASSOC_LV2
`define ASSOC_LV2 4
`endif
`ifndef ASSOC_WID_LV2
`define ASSOC_WID_LV2 2
`endif
`ifndef MESI_WID_LV2
`define MESI_WID_LV2 2
`endif

module victim_alloc_ctrl #(
   parameter int                  ASSOC     = `ASSOC_LV2,
   parameter int                  ASSOC_WID = `ASSOC_WID_LV2,
   parameter int                  MESI_WID  = `MESI_WID_LV2,
   parameter logic [MESI_WID-1:0] INVALID   = MESI_WID'(0),
   parameter logic [MESI_WID-1:0] MODIFIED  = MESI_WID'(3)
) (
   input logic                clk,
   input logic                rst_n,
   victim_alloc_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WB    = 2'd1,
      INV   = 2'd2,
      GRANT = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [ASSOC_WID-1:0] way_q, way_d;

   logic                 busy_q, busy_d;
   logic                 wb_req_q, wb_req_d;
   logic                 inv_req_q, inv_req_d;
   logic                 alloc_gnt_q, alloc_gnt_d;
   logic [ASSOC_WID-1:0] wb_blk_num_q, wb_blk_num_d;
   logic [ASSOC_WID-1:0] inv_blk_num_q, inv_blk_num_d;
   logic [ASSOC_WID-1:0] alloc_blk_num_q, alloc_blk_num_d;

   logic [MESI_WID-1:0]  way_mesi [ASSOC];
   logic                 free_found;
   logic [ASSOC_WID-1:0] free_way;
   logic [ASSOC_WID-1:0] victim_way;
   logic                 victim_dirty;

   // Split the flat set state into ways and find the highest-index INVALID way
   always_comb begin
      free_found = 1'b0;
      free_way   = '0;
      for (int i = 0; i < ASSOC; i++) begin
         way_mesi[i] = bus.cache_proc_mesi[i*MESI_WID +: MESI_WID];
         if (way_mesi[i] == INVALID) begin
            free_found = 1'b1;
            free_way   = ASSOC_WID'(i);
         end
      end
   end

`ifdef ALLOC_RR_VICTIM_EN
   logic [ASSOC_WID-1:0] rr_q;

   // Round-robin victim pointer, advanced once per invalidation
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_q <= '0;
      end else if (inv_req_q) begin
         rr_q <= rr_q + ASSOC_WID'(1);
      end
   end

   assign victim_way = rr_q;
`else
   assign victim_way = bus.lru_blk_num;
`endif

   assign victim_dirty = (way_mesi[victim_way] == MODIFIED);

   // Next-state decision and next values of the registered outputs
   always_comb begin
      state_d = state_q;
      way_d   = way_q;

      case (state_q)
         IDLE: begin
            if (bus.alloc_req && !bus.blk_hit_proc) begin
               if (free_found) begin
                  way_d   = free_way;
                  state_d = GRANT;
               end else begin
                  way_d   = victim_way;
                  state_d = victim_dirty ? WB : INV;
               end
            end
         end
         WB: begin
            if (bus.wb_ack) begin
               state_d = INV;
            end
         end
         INV: begin
            state_d = GRANT;
         end
         GRANT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d          = (state_d != IDLE);
      wb_req_d        = (state_d == WB);
      inv_req_d       = (state_d == INV);
      alloc_gnt_d     = (state_d == GRANT);
      wb_blk_num_d    = way_d;
      inv_blk_num_d   = way_d;
      alloc_blk_num_d = way_d;
   end

   // State, latched way and output registers; reset aborts any sequence
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         way_q           <= '0;
         busy_q          <= 1'b0;
         wb_req_q        <= 1'b0;
         inv_req_q       <= 1'b0;
         alloc_gnt_q     <= 1'b0;
         wb_blk_num_q    <= '0;
         inv_blk_num_q   <= '0;
         alloc_blk_num_q <= '0;
      end else begin
         state_q         <= state_d;
         way_q           <= way_d;
         busy_q          <= busy_d;
         wb_req_q        <= wb_req_d;
         inv_req_q       <= inv_req_d;
         alloc_gnt_q     <= alloc_gnt_d;
         wb_blk_num_q    <= wb_blk_num_d;
         inv_blk_num_q   <= inv_blk_num_d;
         alloc_blk_num_q <= alloc_blk_num_d;
      end
   end

   assign bus.busy          = busy_q;
   assign bus.wb_req        = wb_req_q;
   assign bus.inv_req       = inv_req_q;
   assign bus.alloc_gnt     = alloc_gnt_q;
   assign bus.wb_blk_num    = wb_blk_num_q;
   assign bus.inv_blk_num   = inv_blk_num_q;
   assign bus.alloc_blk_num = alloc_blk_num_q;

endmodule

// File: tb/tb_victim_alloc_ctrl.sv
// tb_victim_alloc_ctrl
// Directed bench for victim_alloc_ctrl with a 4-way set and 2-bit MESI states.
// - Inputs change on the falling edge.
// - Outputs are sampled on the falling edge after each rising edge.
// - Status is compared as the packed vector {busy, wb_req, inv_req, alloc_gnt}.
// Build with ALLOC_RR_VICTIM_EN to exercise the round-robin victim pointer.

module tb_victim_alloc_ctrl;

   logic clk;
   logic rst_n;
   int   errorCount;
   int   checkCount;

   victim_alloc_ctrl_if #(.ASSOC(4), .ASSOC_WID(2), .MESI_WID(2)) bus ();

   victim_alloc_ctrl #(.ASSOC(4), .ASSOC_WID(2), .MESI_WID(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends even if the sequence stalls
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: run did not complete within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against the expected value
   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Drive all requester-side inputs at once
   task automatic applyStimulus(input logic req, input logic hit, input logic [7:0] mesi,
                                input logic [1:0] lru, input logic ack);
      bus.alloc_req       = req;
      bus.blk_hit_proc    = hit;
      bus.cache_proc_mesi = mesi;
      bus.lru_blk_num     = lru;
      bus.wb_ack          = ack;
   endtask

   // Advance one clock and land on the following falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [7:0] status();
      return {4'b0, bus.busy, bus.wb_req, bus.inv_req, bus.alloc_gnt};
   endfunction

`ifdef ALLOC_RR_VICTIM_EN
   logic [1:0] rrExpected [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif

   // Directed scenario sequence
   initial begin
      errorCount = 0;
      checkCount = 0;
      rst_n      = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'h55, 2'd0, 1'b0);
      @(negedge clk);
      tick();
      tick();
      checkOutput("reset_status", status(), 8'h0);
      checkOutput("reset_wb_blk", {6'b0, bus.wb_blk_num}, 8'd0);
      checkOutput("reset_inv_blk", {6'b0, bus.inv_blk_num}, 8'd0);
      checkOutput("reset_alloc_blk", {6'b0, bus.alloc_blk_num}, 8'd0);
      rst_n = 1'b1;
      tick();

      $display("[TB] free way");
      applyStimulus(1'b1, 1'b0, 8'b11_00_01_00, 2'd3, 1'b0);
      tick();
      checkOutput("free_c1_status", status(), 8'b1001);
      checkOutput("free_c1_alloc_blk", {6'b0, bus.alloc_blk_num}, 8'd2);
      applyStimulus(1'b0, 1'b0, 8'b11_00_01_00, 2'd3, 1'b0);
      tick();
      checkOutput("free_c2_status", status(), 8'b0000);

`ifndef ALLOC_RR_VICTIM_EN
      $display("[TB] clean victim then back-to-back dirty victim");
      applyStimulus(1'b1, 1'b0, 8'b01_10_01_10, 2'd1, 1'b0);
      tick();
      checkOutput("clean_c1_status", status(), 8'b1010);
      checkOutput("clean_c1_inv_blk", {6'b0, bus.inv_blk_num}, 8'd1);
      tick();
      checkOutput("clean_c2_status", status(), 8'b1001);
      checkOutput("clean_c2_alloc_blk", {6'b0, bus.alloc_blk_num}, 8'd1);
      applyStimulus(1'b1, 1'b0, 8'hFF, 2'd2, 1'b0);
      tick();
      checkOutput("b2b_idle_status", status(), 8'b0000);
      tick();
      checkOutput("dirty_c1_status", status(), 8'b1100);
      checkOutput("dirty_c1_wb_blk", {6'b0, bus.wb_blk_num}, 8'd2);
      applyStimulus(1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
      tick();
      checkOutput("dirty_c2_status", status(), 8'b1100);
      tick();
      checkOutput("dirty_c3_status", status(), 8'b1100);
      tick();
      checkOutput("dirty_c4_status", status(), 8'b1100);
      checkOutput("dirty_c4_wb_blk", {6'b0, bus.wb_blk_num}, 8'd2);
      bus.wb_ack = 1'b1;
      tick();
      checkOutput("dirty_c5_status", status(), 8'b1010);
      checkOutput("dirty_c5_inv_blk", {6'b0, bus.inv_blk_num}, 8'd2);
      bus.wb_ack = 1'b0;
      tick();
      checkOutput("dirty_c6_status", status(), 8'b1001);
      checkOutput("dirty_c6_alloc_blk", {6'b0, bus.alloc_blk_num}, 8'd2);
      tick();
      checkOutput("dirty_c7_status", status(), 8'b0000);

      $display("[TB] minimum writeback");
      applyStimulus(1'b1, 1'b0, 8'b11_01_11_11, 2'd0, 1'b1);
      tick();
      checkOutput("minwb_c1_status", status(), 8'b1100);
      checkOutput("minwb_c1_wb_blk", {6'b0, bus.wb_blk_num}, 8'd0);
      tick();
      checkOutput("minwb_c2_status", status(), 8'b1010);
      applyStimulus(1'b1, 1'b0, 8'b11_01_11_11, 2'd0, 1'b0);
      tick();
      checkOutput("minwb_c3_status", status(), 8'b1001);
      checkOutput("minwb_c3_alloc_blk", {6'b0, bus.alloc_blk_num}, 8'd0);
      applyStimulus(1'b0, 1'b0, 8'b11_01_11_11, 2'd0, 1'b0);
      tick();
      checkOutput("minwb_c4_status", status(), 8'b0000);
`endif

      $display("[TB] hit suppresses request");
      applyStimulus(1'b1, 1'b1, 8'b00_00_00_00, 2'd1, 1'b1);
      tick();
      checkOutput("hit_c1_status", status(), 8'b0000);
      tick();
      checkOutput("hit_c2_status", status(), 8'b0000);
      applyStimulus(1'b0, 1'b0, 8'hFF, 2'd1, 1'b1);
      tick();
      checkOutput("idle_ack_status", status(), 8'b0000);

      $display("[TB] reset during writeback");
      applyStimulus(1'b1, 1'b0, 8'hFF, 2'd0, 1'b0);
      tick();
      checkOutput("rstwb_c1_status", status(), 8'b1100);
      tick();
      checkOutput("rstwb_c2_status", status(), 8'b1100);
      rst_n = 1'b0;
      tick();
      checkOutput("rstwb_after_status", status(), 8'b0000);
      checkOutput("rstwb_after_wb_blk", {6'b0, bus.wb_blk_num}, 8'd0);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 8'b11_11_00_11, 2'd0, 1'b0);
      tick();
      checkOutput("rstwb_new_status", status(), 8'b1001);
      checkOutput("rstwb_new_alloc_blk", {6'b0, bus.alloc_blk_num}, 8'd1);
      applyStimulus(1'b0, 1'b0, 8'b11_11_00_11, 2'd0, 1'b0);
      tick();
      checkOutput("rstwb_end_status", status(), 8'b0000);

`ifdef ALLOC_RR_VICTIM_EN
      $display("[TB] round-robin victims");
      for (int n = 0; n < 5; n++) begin
         applyStimulus(1'b1, 1'b0, 8'h55, 2'd3, 1'b0);
         tick();
         checkOutput($sformatf("rr%0d_inv_status", n), status(), 8'b1010);
         checkOutput($sformatf("rr%0d_inv_blk", n), {6'b0, bus.inv_blk_num}, {6'b0, rrExpected[n]});
         tick();
         checkOutput($sformatf("rr%0d_alloc_blk", n), {6'b0, bus.alloc_blk_num}, {6'b0, rrExpected[n]});
         applyStimulus(1'b0, 1'b0, 8'h55, 2'd3, 1'b0);
         tick();
      end
`endif

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
